// File: rtl/hdmi_text_pkg.sv
// hdmi_text_pkg: shared constants and types for the HDMI text renderer.
//   Character grid and font geometry, raster limits, the rgb444_t pixel
//   struct, the sync sideband struct and the char-grid address helper.
package hdmi_text_pkg;

  localparam int H_CHARS        = 80;
  localparam int V_CHARS        = 30;
  localparam int CHARS_PER_WORD = 4;
  localparam int WORDS_PER_ROW  = 20;
  localparam int VRAM_WORDS     = 600;
  localparam int CTRL_INDEX     = 600;
  localparam int FONT_W         = 8;
  localparam int FONT_H         = 16;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic vde;
    logic hs;
    logic vs;
  } sync_t;

  // Blanked sideband: no video, syncs at their idle-high level.
  localparam sync_t SYNC_IDLE = 3'b011;

  // row*20 + grp as two shifts and adds, so no multiplier is inferred.
  function automatic logic [9:0] char_word(input logic [4:0] row, input logic [4:0] grp);
    return ({5'd0, row} << 4) + ({5'd0, row} << 2) + {5'd0, grp};
  endfunction

endpackage

// File: rtl/hdmi_font_rom.sv
// hdmi_font_rom: 2048x8 synchronous-read glyph ROM, 1-cycle latency, no reset.
//   clk  - pixel clock
//   addr - {glyph code[6:0], glyph row[3:0]}
//   data - glyph row bits, MSB = leftmost pixel, valid the cycle after addr
// Rows are IBM 8x16 patterns; codes without a listed pattern read as blank.
module hdmi_font_rom
  import hdmi_text_pkg::*;
(
  input  logic              clk,
  input  logic [10:0]       addr,
  output logic [FONT_W-1:0] data
);

  logic [FONT_W-1:0] data_d, data_q;

  always_comb begin
    data_d = '0;
    case (addr)
      // 'A' (0x41)
      11'h412:                            data_d = 8'h10;
      11'h413:                            data_d = 8'h38;
      11'h414:                            data_d = 8'h6C;
      11'h415, 11'h416:                   data_d = 8'hC6;
      11'h417:                            data_d = 8'hFE;
      11'h418, 11'h419, 11'h41A, 11'h41B: data_d = 8'hC6;
      // 'B' (0x42)
      11'h422, 11'h42B:                   data_d = 8'hFC;
      11'h423, 11'h424, 11'h425:          data_d = 8'h66;
      11'h426:                            data_d = 8'h7C;
      11'h427, 11'h428, 11'h429, 11'h42A: data_d = 8'h66;
      // 'H' (0x48)
      11'h482, 11'h483, 11'h484, 11'h485: data_d = 8'hC6;
      11'h486:                            data_d = 8'hFE;
      11'h487, 11'h488, 11'h489, 11'h48A,
      11'h48B:                            data_d = 8'hC6;
      default:                            data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) data_q <= data_d;

  assign data = data_q;

endmodule

// File: rtl/hdmi_text_renderer.sv
// hdmi_text_renderer: 4-stage, stall-free text-mode pixel pipeline.
//   S_AXI_ACLK/S_AXI_ARESETN - pixel clock, async active-low reset
//   draw_x/draw_y/vde/hsync/vsync - raster position and syncs from timing gen
//   vram_addr/vram_rdata - char word fetch (registered read, 1-cycle latency)
//   ctrl - FG/BG colour word, used live in the last stage
//   red/green/blue, vde_o/hsync_o/vsync_o - pixel out, all inputs delayed 4
module hdmi_text_renderer
  import hdmi_text_pkg::*;
(
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        vde,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  vram_addr,
  input  logic [31:0] vram_rdata,
  input  logic [31:0] ctrl,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        vde_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  logic [9:0]  vram_addr_d, vram_addr_q;
  logic [1:0]  s1_byte_d, s1_byte_q, s2_byte_d, s2_byte_q;
  logic [2:0]  s1_px_d, s1_px_q, s2_px_d, s2_px_q, s3_px_d, s3_px_q;
  logic [3:0]  s1_py_d, s1_py_q, s2_py_d, s2_py_q;
  logic        s3_inv_d, s3_inv_q;
  logic [3:1]  inr_pipe_d, inr_pipe_q;
  sync_t [4:1] sb_pipe_d, sb_pipe_q;
  rgb444_t     rgb_d, rgb_q;

  logic        in_range;
  logic [6:0]  col;
  logic [7:0]  char_byte;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pix;
  rgb444_t     fg, bg;

  // Stage 1: char-grid address arithmetic.
  always_comb begin
    in_range    = (draw_x < H_ACTIVE) && (draw_y < V_ACTIVE);
    col         = draw_x[9:3];
    vram_addr_d = in_range ? char_word(draw_y[8:4], col[6:2]) : '0;
    s1_byte_d   = col[1:0];
    s1_px_d     = draw_x[2:0];
    s1_py_d     = draw_y[3:0];
  end

  // Stage 2: VRAM word arrives; pick the char byte and address the ROM.
  // The ROM's own read register is the stage-2/3 boundary for the glyph path.
  always_comb begin
    s2_byte_d = s1_byte_q;
    s2_px_d   = s1_px_q;
    s2_py_d   = s1_py_q;
    char_byte = vram_rdata[{s2_byte_q, 3'b000} +: 8];
    font_addr = {char_byte[6:0], s2_py_q};
    s3_inv_d  = char_byte[7];
    s3_px_d   = s2_px_q;
  end

  // Sideband delay lines: in-range flag to stage 3, syncs to the output.
  always_comb begin
    inr_pipe_d      = {inr_pipe_q[2:1], in_range};
    sb_pipe_d[4:2]  = sb_pipe_q[3:1];
    sb_pipe_d[1]    = {vde, hsync, vsync};
  end

  hdmi_font_rom u_font (
    .clk  (S_AXI_ACLK),
    .addr (font_addr),
    .data (font_data)
  );

  // Stage 3: glyph bit, invert, colour mux. ctrl is not registered on the
  // way in, so a colour change shows up on the very next output cycle.
  always_comb begin
    pix   = font_data[~s3_px_q] ^ s3_inv_q;
    fg    = {ctrl[24:21], ctrl[20:17], ctrl[16:13]};
    bg    = {ctrl[12:9],  ctrl[8:5],   ctrl[4:1]};
    rgb_d = '0;
    if (sb_pipe_q[3].vde && inr_pipe_q[3])
      rgb_d = pix ? fg : bg;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      vram_addr_q <= '0;
      s1_byte_q   <= '0;
      s2_byte_q   <= '0;
      s1_px_q     <= '0;
      s2_px_q     <= '0;
      s3_px_q     <= '0;
      s1_py_q     <= '0;
      s2_py_q     <= '0;
      s3_inv_q    <= 1'b0;
      inr_pipe_q  <= '0;
      sb_pipe_q   <= {4{SYNC_IDLE}};
      rgb_q       <= '0;
    end else begin
      vram_addr_q <= vram_addr_d;
      s1_byte_q   <= s1_byte_d;
      s2_byte_q   <= s2_byte_d;
      s1_px_q     <= s1_px_d;
      s2_px_q     <= s2_px_d;
      s3_px_q     <= s3_px_d;
      s1_py_q     <= s1_py_d;
      s2_py_q     <= s2_py_d;
      s3_inv_q    <= s3_inv_d;
      inr_pipe_q  <= inr_pipe_d;
      sb_pipe_q   <= sb_pipe_d;
      rgb_q       <= rgb_d;
    end
  end

  assign vram_addr = vram_addr_q;
  assign red       = rgb_q.r;
  assign green     = rgb_q.g;
  assign blue      = rgb_q.b;
  assign vde_o     = sb_pipe_q[4].vde;
  assign hsync_o   = sb_pipe_q[4].hs;
  assign vsync_o   = sb_pipe_q[4].vs;

  // ctrl bits outside the colour fields carry nothing for this stage.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl[31:25], ctrl[0]};

endmodule

// File: doc/hdmi_text_renderer.md
# hdmi_text_renderer

Pixel-generation stage downstream of the AXI4-Lite VRAM register file in the HDMI text controller. Takes the VGA timing controller's raster position and sync signals, fetches the character word from VRAM (600 words, 80×30 chars, 4 chars/word) and the glyph row from an internal 8×16 font ROM, and emits 4-bit-per-channel RGB plus delayed syncs to the HDMI encoder. The datapath is a fixed 4-cycle pipeline with no stalls.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- CTRL_INDEX, 600, VRAM word index of the colour control register (informational; ctrl arrives on its own port)
- S_AXI_ACLK  in  1  pixel clock; all logic on its rising edge
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low
- draw_x  in  10  raster column
- draw_y  in  10  raster line
- vde  in  1  video data enable
- hsync  in  1  horizontal sync (polarity passed through)
- vsync  in  1  vertical sync (polarity passed through)
- vram_addr  out  10  VRAM word index 0..599
- vram_rdata  in  32  VRAM word; valid 1 cycle after vram_addr (registered read)
- ctrl  in  32  control word: [24:21] FG_R, [20:17] FG_G, [16:13] FG_B, [12:9] BG_R, [8:5] BG_G, [4:1] BG_B
- red, green, blue  out  4 each  pixel colour
- vde_o, hsync_o, vsync_o  out  1 each  syncs aligned to RGB

## Operation
- Char grid: col = draw_x[9:3], row = draw_y[8:4]; word = row*20 + col[6:2] (computed as row<<4 + row<<2, no multiplier); byte = col[1:0].
- Byte k of a word occupies bits [8k+7:8k]; byte 0 is the leftmost char of the group.
- Char byte: bit 7 = invert, bits 6:0 = glyph code. Font address = {code, draw_y[3:0]} (11 bits, 2048×8 ROM).
- Glyph bit: font_data[7 - draw_x[2:0]] (MSB = leftmost pixel). pix = glyph bit XOR invert.
- pix=1 -> FG colour, pix=0 -> BG colour.
- Out-of-range (draw_x ≥ H_ACTIVE or draw_y ≥ V_ACTIVE): vram_addr forced to 0, RGB forced to 0.
- vde_o=0 -> RGB = 0 regardless of pix.

## Timing
- Stage 1 (t+1): register vram_addr, byte select, draw_x[2:0], draw_y[3:0], in-range flag, syncs.
- Stage 2 (t+2): vram_rdata valid; select byte; register font address, invert bit, pipe sideband.
- Stage 3 (t+3): font ROM data valid; compute pix; sample ctrl here.
- Stage 4 (t+4): RGB, vde_o, hsync_o, vsync_o registered out. Input-to-output latency exactly 4 cycles for every signal.
- ctrl change at cycle c is visible on RGB at c+1 (sampled in stage 3, registered in stage 4); no frame-boundary synchronisation.
- Reset (asynchronous, any time incl. mid-line): all pipeline regs cleared; red/green/blue=0, vde_o=0, hsync_o=1, vsync_o=1, vram_addr=0. First valid output 4 cycles after the first post-reset input.
- Pipeline never stalls; a new pixel every cycle, back-to-back line wrap (draw_x 639->0) needs no bubble.

## Structure
- Package hdmi_text_pkg: H_CHARS=80, V_CHARS=30, CHARS_PER_WORD=4, WORDS_PER_ROW=20, VRAM_WORDS=600, CTRL_INDEX=600, FONT_W=8, FONT_H=16, and a packed rgb444_t struct {r,g,b}.
- One sub-module: hdmi_font_rom — 2048×8 synchronous-read ROM (IBM 8×16 glyph set), 1-cycle latency, no reset.
- Top holds address arithmetic, sideband delay line, colour mux.

## Test plan
- Reset asserted mid-line with vde=1 -> same cycle red/green/blue=0, vde_o=0, hsync_o=vsync_o=1, vram_addr=0.
- draw_x=639, draw_y=479 -> vram_addr=599 one cycle later; byte 3 selected; draw_x=8, draw_y=16 -> vram_addr=20, byte 1.
- Word 0 = 0x00000080, ctrl FG=F,0,0 BG=0,0,F; scan draw_x 0..7, draw_y 0..15 -> all 128 pixels red=F green=0 blue=0 (glyph 0 blank, inverted).
- Word 0 = 0x00000000, same ctrl -> pixels 0..7 red=0 blue=F; same with vde=0 -> RGB=0.
- Single-cycle pulse on vde/hsync/vsync at t -> pulse on vde_o/hsync_o/vsync_o at exactly t+4, width 1.
- draw_x=700, draw_y=10, vde=1 -> vram_addr=0, RGB=0 at t+4; ctrl change FG F00->0F0 mid-line -> RGB switches exactly one cycle later.
